// File: rtl/aes_pkg.sv
// Shared AES control definitions for the encrypt- and decrypt-side state managers.
// Holds the controller state encodings and the state-matrix input-source codes.
package aes_pkg;

  typedef enum logic [5:0] {
    IDLE              = 6'd0,
    CTEXT_WRITE       = 6'd1,
    KEY_WRITE         = 6'd2,
    COMPUTE_ROUNDKEYS = 6'd3,
    INIT_ADDROUNDKEY  = 6'd4,
    INV_SHIFTROWS     = 6'd5,
    INV_SUBBYTES      = 6'd6,
    ADDROUNDKEY       = 6'd7,
    INV_MIXCOLUMNS    = 6'd8,
    DECRYPTION_DONE   = 6'd9,
    PTEXT_READ        = 6'd10
  } state_t;

  typedef enum logic [3:0] {
    SEL_EXTERNAL     = 4'd0,
    SEL_ADDROUNDKEY  = 4'd4,
    SEL_INVSUBBYTES  = 4'd5,
    SEL_INVSHIFTROWS = 4'd6,
    SEL_INVMIXCOLS   = 4'd7
  } mat_sel_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

endpackage

// File: rtl/aes_dec_state_manager_if.sv
// Control bus between the AES decrypt state manager and its host/datapath.
//   master: host side (drives start requests and key-expansion status)
//   slave : state manager (drives status, debug and state-matrix controls)
interface aes_dec_state_manager_if;

  logic       start_write_n;
  logic       start_read_n;
  logic       key_expand_done;
  logic       done;
  logic [5:0] dbg_state;
  logic [3:0] dbg_round;
  logic [3:0] round_key_idx;
  logic [3:0] matrix_in_sel;
  logic       matrix_write_enable;
  logic       input_mat_row_col;
  logic       output_mat_row_col;
  logic [1:0] input_mat_idx;
  logic [1:0] output_mat_idx;
  logic       key_start;

  modport master (
    output start_write_n, start_read_n, key_expand_done,
    input  done, dbg_state, dbg_round, round_key_idx, matrix_in_sel,
           matrix_write_enable, input_mat_row_col, output_mat_row_col,
           input_mat_idx, output_mat_idx, key_start
  );

  modport slave (
    input  start_write_n, start_read_n, key_expand_done,
    output done, dbg_state, dbg_round, round_key_idx, matrix_in_sel,
           matrix_write_enable, input_mat_row_col, output_mat_row_col,
           input_mat_idx, output_mat_idx, key_start
  );

endinterface

// File: rtl/aes_dec_round_counter.sv
// Round number and 4-cycle sub-step counter for the AES decrypt controller.
//   clock, reset_n : clock, async active-low reset
//   cnt_step/clr   : advance / clear the 2-bit count_4
//   rnd_load/val   : load round; rnd_dec: decrement (saturates at 0); rnd_clr: clear
//   count, round   : registered counter values
module aes_dec_round_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cnt_step,
  input  logic       cnt_clr,
  input  logic       rnd_load,
  input  logic [3:0] rnd_load_val,
  input  logic       rnd_dec,
  input  logic       rnd_clr,
  output logic [1:0] count,
  output logic [3:0] round
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      round <= '0;
    end else begin
      if (cnt_clr)       count <= '0;
      else if (cnt_step) count <= count + 2'd1;

      if (rnd_clr)                    round <= '0;
      else if (rnd_load)              round <= rnd_load_val;
      else if (rnd_dec && round != '0) round <= round - 4'd1;
    end
  end

endmodule

// File: rtl/aes_dec_state_manager.sv
// AES-128 decryption controller: sequences ciphertext/key load, waits for key
// expansion, runs the 10 inverse rounds and hands out the plaintext.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : start requests, key_expand_done, done, debug and
//                    state-matrix select/write/row-col/index controls, key_start
module aes_dec_state_manager
  import aes_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  aes_dec_state_manager_if.slave      bus
);

  state_t     state, state_next;
  logic [1:0] count;
  logic [3:0] round;
  logic       cnt_step, cnt_clr_fault, rnd_load, rnd_dec, rnd_clr;
  logic [3:0] rnd_load_val;
  logic       last;

  assign last = (count == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cnt_step      = 1'b0;
    cnt_clr_fault = 1'b0;
    rnd_load      = 1'b0;
    rnd_load_val  = '0;
    rnd_dec       = 1'b0;
    rnd_clr       = 1'b0;
    unique case (state)
      IDLE:              if (!bus.start_write_n) state_next = CTEXT_WRITE;
      CTEXT_WRITE: begin
        cnt_step = 1'b1;
        if (last) state_next = KEY_WRITE;
      end
      KEY_WRITE: begin
        cnt_step = 1'b1;
        if (last) state_next = COMPUTE_ROUNDKEYS;
      end
      COMPUTE_ROUNDKEYS: if (bus.key_expand_done) begin
        state_next   = INIT_ADDROUNDKEY;
        rnd_load     = 1'b1;
        rnd_load_val = LAST_ROUND;
      end
      INIT_ADDROUNDKEY: begin
        cnt_step = 1'b1;
        if (last) begin
          state_next   = INV_SHIFTROWS;
          rnd_load     = 1'b1;
          rnd_load_val = LAST_ROUND - 4'd1;
        end
      end
      INV_SHIFTROWS: begin
        cnt_step = 1'b1;
        if (last) state_next = INV_SUBBYTES;
      end
      INV_SUBBYTES: begin
        cnt_step = 1'b1;
        if (last) state_next = ADDROUNDKEY;
      end
      ADDROUNDKEY: begin
        cnt_step = 1'b1;
        if (last) state_next = (round == '0) ? DECRYPTION_DONE : INV_MIXCOLUMNS;
      end
      INV_MIXCOLUMNS: begin
        cnt_step = 1'b1;
        if (last) begin
          state_next = INV_SHIFTROWS;
          rnd_dec    = 1'b1;
        end
      end
      DECRYPTION_DONE:   if (!bus.start_read_n) state_next = PTEXT_READ;
      PTEXT_READ: begin
        cnt_step = 1'b1;
        if (last) state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        cnt_clr_fault = 1'b1;
        rnd_clr       = 1'b1;
      end
    endcase
  end

  // count_4 restarts at 0 on every state change.
  aes_dec_round_counter u_round_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .cnt_step     (cnt_step),
    .cnt_clr      (cnt_clr_fault || (state_next != state)),
    .rnd_load     (rnd_load),
    .rnd_load_val (rnd_load_val),
    .rnd_dec      (rnd_dec),
    .rnd_clr      (rnd_clr),
    .count        (count),
    .round        (round)
  );

  always_comb begin
    bus.matrix_in_sel       = SEL_EXTERNAL;
    bus.matrix_write_enable = 1'b0;
    bus.input_mat_row_col   = 1'b0;
    bus.output_mat_row_col  = 1'b0;
    bus.input_mat_idx       = '0;
    bus.output_mat_idx      = '0;
    unique case (state)
      CTEXT_WRITE: begin
        bus.matrix_write_enable = 1'b1;
        bus.input_mat_row_col   = 1'b1;
        bus.input_mat_idx       = count;
      end
      INIT_ADDROUNDKEY, ADDROUNDKEY: begin
        bus.matrix_in_sel       = SEL_ADDROUNDKEY;
        bus.matrix_write_enable = 1'b1;
        bus.input_mat_row_col   = 1'b1;
        bus.output_mat_row_col  = 1'b1;
        bus.input_mat_idx       = count;
        bus.output_mat_idx      = count;
      end
      INV_SHIFTROWS: begin
        bus.matrix_in_sel       = SEL_INVSHIFTROWS;
        bus.matrix_write_enable = 1'b1;
        bus.input_mat_idx       = count;
        bus.output_mat_idx      = count;
      end
      INV_SUBBYTES: begin
        bus.matrix_in_sel       = SEL_INVSUBBYTES;
        bus.matrix_write_enable = 1'b1;
        bus.input_mat_idx       = count;
        bus.output_mat_idx      = count;
      end
      INV_MIXCOLUMNS: begin
        bus.matrix_in_sel       = SEL_INVMIXCOLS;
        bus.matrix_write_enable = 1'b1;
        bus.input_mat_row_col   = 1'b1;
        bus.output_mat_row_col  = 1'b1;
        bus.input_mat_idx       = count;
        bus.output_mat_idx      = count;
      end
      PTEXT_READ: begin
        bus.output_mat_row_col  = 1'b1;
        bus.output_mat_idx      = count;
      end
      default: ;
    endcase
  end

  assign bus.dbg_state     = state;
  assign bus.dbg_round     = round;
  assign bus.round_key_idx = round;
  assign bus.done          = (state == DECRYPTION_DONE);
  assign bus.key_start     = (state == KEY_WRITE) && (count == 2'd0);

endmodule

// File: tb/tb_aes_dec_state_manager.sv
module tb_aes_dec_state_manager;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  aes_dec_state_manager_if bus ();

  aes_dec_state_manager dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] all_outs();
    return {bus.done, bus.dbg_state, bus.dbg_round, bus.round_key_idx,
            bus.matrix_in_sel, bus.matrix_write_enable, bus.input_mat_row_col,
            bus.output_mat_row_col, bus.input_mat_idx, bus.output_mat_idx,
            bus.key_start};
  endfunction

  // Ciphertext load, key load, then COMPUTE_ROUNDKEYS held for 20 cycles.
  task automatic do_load();
    bus.start_write_n = 1'b0;
    tick();
    bus.start_write_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ctext_state", 32'(bus.dbg_state), 32'd1);
      chk("ctext_we", 32'(bus.matrix_write_enable), 32'd1);
      chk("ctext_rc", 32'(bus.input_mat_row_col), 32'd1);
      chk("ctext_sel", 32'(bus.matrix_in_sel), 32'd0);
      chk("ctext_idx", 32'(bus.input_mat_idx), 32'(i));
      tick();
    end
    chk("key_state", 32'(bus.dbg_state), 32'd2);
    chk("key_start_first", 32'(bus.key_start), 32'd1);
    tick();
    chk("key_start_second", 32'(bus.key_start), 32'd0);
    tick();
    chk("key_start_third", 32'(bus.key_start), 32'd0);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("compute_hold", 32'(bus.dbg_state), 32'd3);
      tick();
    end
    chk("compute_hold_end", 32'(bus.dbg_state), 32'd3);
    bus.key_expand_done = 1'b1;
    tick();
    bus.key_expand_done = 1'b0;
    chk("init_state", 32'(bus.dbg_state), 32'd4);
    chk("init_rki", 32'(bus.round_key_idx), 32'd10);
    chk("init_sel", 32'(bus.matrix_in_sel), 32'd4);
    chk("init_rc", {30'd0, bus.input_mat_row_col, bus.output_mat_row_col}, 32'd3);
  endtask

  // Steps n edges after INIT_ADDROUNDKEY entry; start_read_n is pulled low
  // mid-run to show it is ignored.
  task automatic do_decrypt(input int stop_n);
    int m, blk, ph;
    logic [5:0] es;
    logic [3:0] er, esel;
    for (int n = 1; n <= stop_n; n++) begin
      bus.start_read_n = !(n >= 40 && n < 60);
      tick();
      if (n < 4) begin
        es = 6'd4; er = 4'd10; esel = 4'd4;
      end else if (n == 160) begin
        es = 6'd9; er = 4'd0; esel = 4'd0;
      end else begin
        m = n - 4; blk = m / 16; ph = (m % 16) / 4;
        er = 4'(9 - blk);
        case (ph)
          0: begin es = 6'd5; esel = 4'd6; end
          1: begin es = 6'd6; esel = 4'd5; end
          2: begin es = 6'd7; esel = 4'd4; end
          default: begin es = 6'd8; esel = 4'd7; end
        endcase
      end
      chk($sformatf("run_state_%0d", n), 32'(bus.dbg_state), 32'(es));
      chk($sformatf("run_rki_%0d", n), 32'(bus.round_key_idx), 32'(er));
      chk($sformatf("run_sel_%0d", n), 32'(bus.matrix_in_sel), 32'(esel));
      chk($sformatf("run_done_%0d", n), 32'(bus.done), (n == 160) ? 32'd1 : 32'd0);
      chk($sformatf("run_idx_%0d", n), 32'(bus.input_mat_idx), (n == 160) ? 32'd0 : 32'(n % 4));
    end
    bus.start_read_n = 1'b1;
  endtask

  task automatic do_read();
    bus.start_write_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_ignore_write", 32'(bus.dbg_state), 32'd9);
      chk("done_ignore_round", 32'(bus.dbg_round), 32'd0);
      chk("done_level", 32'(bus.done), 32'd1);
    end
    bus.start_write_n = 1'b1;
    bus.start_read_n = 1'b0;
    tick();
    bus.start_read_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ptext_state", 32'(bus.dbg_state), 32'd10);
      chk("ptext_orc", 32'(bus.output_mat_row_col), 32'd1);
      chk("ptext_oidx", 32'(bus.output_mat_idx), 32'(i));
      chk("ptext_we", 32'(bus.matrix_write_enable), 32'd0);
      tick();
    end
    chk("back_idle", 32'(bus.dbg_state), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start_write_n   = 1'b1;
    bus.start_read_n    = 1'b1;
    bus.key_expand_done = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_outputs", 32'(all_outs()), 32'd0);

    do_load();
    do_decrypt(160);
    do_read();

    // Abort in INV_SUBBYTES of round 5 (edge 73 after INIT entry).
    do_load();
    do_decrypt(73);
    chk("pre_abort_state", 32'(bus.dbg_state), 32'd6);
    chk("pre_abort_round", 32'(bus.dbg_round), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", 32'(all_outs()), 32'd0);
    tick();
    chk("abort_hold", 32'(all_outs()), 32'd0);
    reset_n = 1'b1;
    tick();

    do_load();
    do_decrypt(160);
    do_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
